// File: rtl/ttt_move_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_move_ctrl
//
// Move controller for the tic-tac-toe datapath. Sits upstream of the
// cell-enable decoder: turns debounced button levels into a cursor index,
// commits the current player's mark with a one-cycle write strobe, tracks
// board occupancy, alternates turns and detects a win or a draw.
//
// Parameters
//   CURSOR_INIT  cursor index loaded on reset and on a new game (0..8)
//
// Ports
//   clk        in   system clock, rising-edge active
//   rst        in   asynchronous, active-high reset
//   btn_left   in   debounced level, move cursor one column left (wraps)
//   btn_right  in   debounced level, move cursor one column right (wraps)
//   btn_up     in   debounced level, move cursor one row up (wraps)
//   btn_down   in   debounced level, move cursor one row down (wraps)
//   btn_place  in   debounced level, place a mark / start a new game in DONE
//   sel        out  cursor cell index row*3+col, always 0..8
//   wr_en      out  one-cycle strobe: mark committed at cell sel
//   wr_player  out  owner of the committed mark (0 = X, 1 = O)
//   turn       out  player to move (0 = X, 1 = O)
//   board_x    out  bit i set = cell i holds X
//   board_o    out  bit i set = cell i holds O
//   illegal    out  one-cycle pulse after a place on an occupied cell
//   game_over  out  high while the game is finished
//   winner     out  00 none, 01 X, 10 O, 11 draw
// ---------------------------------------------------------------------------
module ttt_move_ctrl #(
  parameter int unsigned CURSOR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_place,
  output logic [3:0] sel,
  output logic       wr_en,
  output logic       wr_player,
  output logic       turn,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       illegal,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [3:0] SEL_INIT = 4'(CURSOR_INIT);

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    COMMIT = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // One action per cycle, chosen by fixed priority among the edge events.
  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_PLACE = 3'd1,
    ACT_LEFT  = 3'd2,
    ACT_RIGHT = 3'd3,
    ACT_UP    = 3'd4,
    ACT_DOWN  = 3'd5
  } act_t;

  state_t     state;
  state_t     state_nxt;
  act_t       act;

  // Button vectors are ordered {place, left, right, up, down}.
  logic [4:0] btn_now;
  logic [4:0] btn_hist;
  logic [4:0] btn_ev;

  logic [8:0] occupied;
  logic [8:0] sel_mask;
  logic       cell_free;
  logic       board_full;
  logic       mover_wins;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------

  // True when any of the 8 lines is fully owned in the given board.
  function automatic logic has_line(input logic [8:0] b);
    logic rows, cols, diags;
    rows  = (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]);
    cols  = (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]);
    diags = (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    return rows | cols | diags;
  endfunction

  // Cursor movement with wrap inside the current row (left/right) or
  // column (up/down). Tables keep the index arithmetic out of the datapath.
  function automatic logic [3:0] cursor_step(input logic [3:0] s, input act_t a);
    logic [3:0] n;
    n = s;
    unique case (a)
      ACT_LEFT: begin
        case (s)
          4'd0: n = 4'd2;  4'd1: n = 4'd0;  4'd2: n = 4'd1;
          4'd3: n = 4'd5;  4'd4: n = 4'd3;  4'd5: n = 4'd4;
          4'd6: n = 4'd8;  4'd7: n = 4'd6;  4'd8: n = 4'd7;
          default: n = SEL_INIT;
        endcase
      end
      ACT_RIGHT: begin
        case (s)
          4'd0: n = 4'd1;  4'd1: n = 4'd2;  4'd2: n = 4'd0;
          4'd3: n = 4'd4;  4'd4: n = 4'd5;  4'd5: n = 4'd3;
          4'd6: n = 4'd7;  4'd7: n = 4'd8;  4'd8: n = 4'd6;
          default: n = SEL_INIT;
        endcase
      end
      ACT_UP: begin
        case (s)
          4'd0: n = 4'd6;  4'd1: n = 4'd7;  4'd2: n = 4'd8;
          4'd3: n = 4'd0;  4'd4: n = 4'd1;  4'd5: n = 4'd2;
          4'd6: n = 4'd3;  4'd7: n = 4'd4;  4'd8: n = 4'd5;
          default: n = SEL_INIT;
        endcase
      end
      ACT_DOWN: begin
        case (s)
          4'd0: n = 4'd3;  4'd1: n = 4'd4;  4'd2: n = 4'd5;
          4'd3: n = 4'd6;  4'd4: n = 4'd7;  4'd5: n = 4'd8;
          4'd6: n = 4'd0;  4'd7: n = 4'd1;  4'd8: n = 4'd2;
          default: n = SEL_INIT;
        endcase
      end
      default: n = s;
    endcase
    return n;
  endfunction

  // -------------------------------------------------------------------------
  // Edge detection and action priority
  // -------------------------------------------------------------------------
  assign btn_now = {btn_place, btn_left, btn_right, btn_up, btn_down};
  assign btn_ev  = btn_now & ~btn_hist;

  // NOTE: every variable written in an always_comb gets a default at the
  // top of the block; without it a missed branch would infer a latch.
  always_comb begin
    act = ACT_NONE;
    if      (btn_ev[4]) act = ACT_PLACE;
    else if (btn_ev[3]) act = ACT_LEFT;
    else if (btn_ev[2]) act = ACT_RIGHT;
    else if (btn_ev[1]) act = ACT_UP;
    else if (btn_ev[0]) act = ACT_DOWN;
  end

  // -------------------------------------------------------------------------
  // Board status
  // -------------------------------------------------------------------------
  assign occupied   = board_x | board_o;
  assign sel_mask   = 9'd1 << sel;
  assign cell_free  = ~occupied[sel];
  assign board_full = &occupied;
  // In CHECK, turn still names the player who just moved.
  assign mover_wins = has_line(turn ? board_o : board_x);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PLAY;
    else     state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      PLAY:   if (act == ACT_PLACE && cell_free) state_nxt = COMMIT;
      COMMIT: state_nxt = CHECK;
      CHECK:  state_nxt = (mover_wins || board_full) ? DONE : PLAY;
      DONE:   if (act == ACT_PLACE) state_nxt = PLAY;
      default: state_nxt = PLAY;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // -------------------------------------------------------------------------
  always_comb begin
    wr_en     = 1'b0;
    game_over = 1'b0;
    wr_player = turn;
    unique case (state)
      COMMIT:  wr_en     = 1'b1;
      DONE:    game_over = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: history, cursor, board, turn, result, illegal pulse
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_hist <= '0;
      sel      <= SEL_INIT;
      board_x  <= '0;
      board_o  <= '0;
      turn     <= 1'b0;
      illegal  <= 1'b0;
      winner   <= 2'b00;
    end else begin
      // History follows the buttons in every state, so events seen during
      // COMMIT/CHECK are consumed and dropped rather than queued.
      btn_hist <= btn_now;
      illegal  <= 1'b0;

      unique case (state)
        PLAY: begin
          if (act == ACT_PLACE) begin
            if (!cell_free) illegal <= 1'b1;
          end else begin
            sel <= cursor_step(sel, act);
          end
        end

        COMMIT: begin
          if (turn) board_o <= board_o | sel_mask;
          else      board_x <= board_x | sel_mask;
        end

        CHECK: begin
          if (mover_wins)      winner <= turn ? 2'b10 : 2'b01;
          else if (board_full) winner <= 2'b11;
          else                 turn   <= ~turn;
        end

        DONE: begin
          if (act == ACT_PLACE) begin
            board_x <= '0;
            board_o <= '0;
            sel     <= SEL_INIT;
            turn    <= 1'b0;
            winner  <= 2'b00;
          end
        end

        default: ;
      endcase
    end
  end

endmodule
